cpu_trace_buffer: RTL and testbench
===================================

Name: cpu_trace_buffer

Overview:
- Synthesisable on-chip execution trace recorder for the 16-bit CPU; RTL successor of the cycle-print trace monitor.
- Sits beside the core on the retire stage. Captures one entry per retired instruction into a parametrised circular buffer.
- Supports PC-match or forced trigger, post-trigger capture count, and oldest-first valid/ready readout.

Parameters:
- PC_W, 16, program counter width
- DATA_W, 16, instruction and write-data width
- TAG_W, 16, write tag width: register index (zero-extended) or data-memory address
- DEPTH, 8, entry count; power of two, >= 2
- POST_TRIG, 2, entries captured after the trigger entry; 0 <= POST_TRIG < DEPTH

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- cap_valid  in  1  one instruction retires this cycle
- cap_pc  in  PC_W  PC of the retiring instruction
- cap_instr  in  DATA_W  instruction word
- cap_kind  in  2  write kind: 0 none, 1 register, 2 memory, 3 reserved (stored as is)
- cap_tag  in  TAG_W  register index or memory address
- cap_data  in  DATA_W  written value
- arm  in  1  pulse: clear the buffer and start capture
- trig_en  in  1  enable PC-match trigger
- trig_pc  in  PC_W  trigger PC
- force_trig  in  1  pulse: trigger on the next captured entry
- armed  out  1  state is ARMED or POST
- triggered  out  1  state is POST or DONE
- done  out  1  state is DONE
- fill  out  clog2(DEPTH+1)  valid entries held
- trig_pos  out  clog2(DEPTH)  readout index of the trigger entry
- rd_valid  out  1  readout entry available
- rd_ready  in  1  consumer accepts the entry
- rd_data  out  PC_W+2*DATA_W+2+TAG_W  entry packed as {pc, instr, kind, tag, data}

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state IDLE
  - all outputs 0
  - write pointer, read pointer, fill and post counter 0
  - sticky force flag cleared
  - Entry storage is not reset.
- State IDLE:
  - cap_valid is ignored.
  - arm=1 -> ARMED; write pointer and fill cleared.
- State ARMED:
  - On cap_valid, the entry is written at wr_ptr and wr_ptr increments modulo DEPTH.
  - fill increments, saturating at DEPTH; the oldest entry is overwritten on wrap.
  - Trigger condition: cap_valid && ((trig_en && cap_pc==trig_pc) || force pending).
  - force_trig sets the sticky force flag; the next captured entry consumes it.
  - On trigger, the triggering entry is written. Then:
    - POST_TRIG==0 -> DONE
    - otherwise -> POST with post_cnt=POST_TRIG
- State POST:
  - Capture continues as in ARMED; further matches are ignored.
  - post_cnt decrements per captured entry.
  - The write that brings post_cnt to 0 -> DONE on that edge.
- State DONE:
  - Capture is frozen.
  - rd_ptr = (fill==DEPTH) ? wr_ptr : 0.
  - trig_pos = fill-1-POST_TRIG.
  - rd_valid=1 while unread entries remain.
  - rd_data is combinational from storage at rd_ptr and is stable while rd_valid && !rd_ready.
  - rd_valid && rd_ready advances rd_ptr modulo DEPTH.
  - When the final entry is accepted -> IDLE; done and rd_valid drop on the next edge.
- arm priority:
  - arm in ARMED, POST or DONE restarts capture (clear, -> ARMED) and aborts any readout.
  - arm takes priority over a same-cycle cap_valid: the entry is dropped.
  - arm takes priority over a same-cycle rd_ready handshake: the handshake does not count.
- trig_pos is held from DONE entry until the next arm; outputs 0 in IDLE/ARMED.
- Latency: an entry becomes readable 1 clk after the write edge that completes capture.

Optional Feature:
- TRACE_CHANGE_FILTER_EN defined:
  - In ARMED/POST, entries with cap_kind==0 are discarded. This mirrors change-only logging.
  - Exception: a triggering entry is always stored.
  - Discarded entries do not decrement post_cnt.
  - A PC match on a discarded entry still fires the trigger, and that entry is stored.
- Undefined: every cap_valid entry is stored.

Test Plan:
- Reset: hold rst=0 with arm=1 and cap_valid=1 -> all outputs 0; release rst -> state IDLE, fill=0, rd_valid=0.
- Basic trigger (DEPTH=8, POST_TRIG=2, trig_en=1, trig_pc=2): arm, then retire pc 0,1,2,3,4 -> done=1, fill=5, trig_pos=2; readout pc 0,1,2,3,4 in order, then done=0.
- Wrap: arm, retire pc 0..11, trig_pc=9 -> fill=8, trig_pos=5; readout pc 4..11.
- Backpressure: rd_ready pattern 1,0,0,1,0,1,... -> each entry delivered exactly once, in order; rd_data unchanged during stalls.
- Abort:
  - arm asserted during POST, same cycle as cap_valid -> armed=1, fill=0, entry dropped.
  - rst=0 mid-readout -> rd_valid=0 immediately, state IDLE.
- Filter (TRACE_CHANGE_FILTER_EN, force_trig): retire kinds 0,1,0,2,0,1,2 with force_trig pulsed before the 3rd -> stored entries are #2, #3 (trigger, kind 0), #4 and #6; fill=4; trig_pos=1.

Source files
------------

// File: rtl/cpu_trace_buffer.sv
// Retire-stage execution trace recorder: circular entry store with PC/forced trigger,
// post-trigger capture and oldest-first readout. Define TRACE_CHANGE_FILTER_EN to drop kind-0 entries.
module cpu_trace_buffer #(
  parameter int PC_W      = 16,
  parameter int DATA_W    = 16,
  parameter int TAG_W     = 16,
  parameter int DEPTH     = 8,
  parameter int POST_TRIG = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cap_valid,
  input  logic [PC_W-1:0]                   cap_pc,
  input  logic [DATA_W-1:0]                 cap_instr,
  input  logic [1:0]                        cap_kind,
  input  logic [TAG_W-1:0]                  cap_tag,
  input  logic [DATA_W-1:0]                 cap_data,
  input  logic                              arm,
  input  logic                              trig_en,
  input  logic [PC_W-1:0]                   trig_pc,
  input  logic                              force_trig,
  output logic                              armed,
  output logic                              triggered,
  output logic                              done,
  output logic [$clog2(DEPTH+1)-1:0]        fill,
  output logic [$clog2(DEPTH)-1:0]          trig_pos,
  output logic                              rd_valid,
  input  logic                              rd_ready,
  output logic [PC_W+2*DATA_W+2+TAG_W-1:0]  rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH+1);
  localparam int EW = PC_W + 2*DATA_W + 2 + TAG_W;
  localparam logic [FW-1:0] FullCount = FW'(DEPTH);

`ifdef TRACE_CHANGE_FILTER_EN
  localparam bit FilterEn = 1'b1;
`else
  localparam bit FilterEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wrPtr_q, wrPtr_d;
  logic [AW-1:0]   rdPtr_q, rdPtr_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [FW-1:0]   postCnt_q, postCnt_d;
  logic [FW-1:0]   remain_q, remain_d;
  logic [AW-1:0]   trigPos_q, trigPos_d;
  logic            force_q, force_d;
  logic            hit, store, finish;
  logic [EW-1:0]   mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      fill_q    <= '0;
      postCnt_q <= '0;
      remain_q  <= '0;
      trigPos_q <= '0;
      force_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      fill_q    <= fill_d;
      postCnt_q <= postCnt_d;
      remain_q  <= remain_d;
      trigPos_q <= trigPos_d;
      force_q   <= force_d;
    end
  end

  // Entry storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (store) mem[wrPtr_q] <= {cap_pc, cap_instr, cap_kind, cap_tag, cap_data};
  end

  always_comb begin
    state_d   = state_q;
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    fill_d    = fill_q;
    postCnt_d = postCnt_q;
    remain_d  = remain_q;
    trigPos_d = trigPos_q;
    force_d   = force_q;
    hit       = 1'b0;
    store     = 1'b0;
    finish    = 1'b0;
    if (arm) begin
      state_d   = ARMED;
      wrPtr_d   = '0;
      fill_d    = '0;
      postCnt_d = '0;
      remain_d  = '0;
      trigPos_d = '0;
      force_d   = 1'b0;
    end else begin
      case (state_q)
        ARMED, POST: begin
          hit   = (state_q == ARMED) && cap_valid && ((trig_en && cap_pc == trig_pc) || force_q);
          store = cap_valid && (!FilterEn || cap_kind != 2'd0 || hit);
          if (store) begin
            wrPtr_d = wrPtr_q + 1'b1;
            if (fill_q != FullCount) fill_d = fill_q + 1'b1;
          end
          if (state_q == ARMED && force_trig) force_d = 1'b1;
          if (hit) begin
            force_d = 1'b0;
            if (POST_TRIG == 0) begin
              finish = 1'b1;
            end else begin
              state_d   = POST;
              postCnt_d = FW'(POST_TRIG);
            end
          end else if (state_q == POST && store) begin
            postCnt_d = postCnt_q - 1'b1;
            if (postCnt_q == FW'(1)) finish = 1'b1;
          end
          // Once wrapped, the oldest surviving entry sits at the next write slot.
          if (finish) begin
            state_d   = DONE;
            rdPtr_d   = (fill_d == FullCount) ? wrPtr_d : '0;
            remain_d  = fill_d;
            trigPos_d = AW'(fill_d - FW'(1) - FW'(POST_TRIG));
          end
        end
        DONE: begin
          if (remain_q != '0 && rd_ready) begin
            rdPtr_d  = rdPtr_q + 1'b1;
            remain_d = remain_q - 1'b1;
            if (remain_q == FW'(1)) state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign armed     = (state_q == ARMED) || (state_q == POST);
  assign triggered = (state_q == POST) || (state_q == DONE);
  assign done      = (state_q == DONE);
  assign fill      = fill_q;
  assign trig_pos  = (state_q == DONE) ? trigPos_q : '0;
  assign rd_valid  = (state_q == DONE) && (remain_q != '0);
  assign rd_data   = rd_valid ? mem[rdPtr_q] : '0;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: vector table, directed corner cases and
// randomized trials against a list-based capture model (honours TRACE_CHANGE_FILTER_EN).
module tb_cpu_trace_buffer;

  localparam int PC_W = 16, DATA_W = 16, TAG_W = 16, DEPTH = 8, POST_TRIG = 2;
  localparam int EW = PC_W + 2*DATA_W + 2 + TAG_W;
  localparam int FW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

`ifdef TRACE_CHANGE_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic              clk, rst;
  logic              cap_valid, arm, trig_en, force_trig, rd_ready;
  logic [PC_W-1:0]   cap_pc, trig_pc;
  logic [DATA_W-1:0] cap_instr, cap_data;
  logic [1:0]        cap_kind;
  logic [TAG_W-1:0]  cap_tag;
  logic              armed, triggered, done, rd_valid;
  logic [FW-1:0]     fill;
  logic [AW-1:0]     trig_pos;
  logic [EW-1:0]     rd_data;

  int nCompared = 0;
  int nMismatched = 0;

  cpu_trace_buffer #(.PC_W(PC_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)) dut (
    .clk(clk), .rst(rst), .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr),
    .cap_kind(cap_kind), .cap_tag(cap_tag), .cap_data(cap_data), .arm(arm), .trig_en(trig_en),
    .trig_pc(trig_pc), .force_trig(force_trig), .armed(armed), .triggered(triggered), .done(done),
    .fill(fill), .trig_pos(trig_pos), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    bit arm; bit capV; int pc; bit rdy;
    int expArmed; int expTrig; int expDone; int expFill; int expTp; int expRv; int expPc;
  } vec_t;

  vec_t vecs[11];
  logic [EW-1:0] expQ[$];
  logic [EW-1:0] mList[$];

  function automatic logic [EW-1:0] fixedEntry(input int pc, input int kind);
    logic [15:0] p;
    p = 16'(pc);
    return {p, p ^ 16'hA5A5, 2'(kind), p + 16'd3, p * 16'd7};
  endfunction

  function automatic vec_t mkVec(input bit a, input bit cv, input int pc, input bit r, input int ea,
                                 input int et, input int ed, input int ef, input int etp,
                                 input int erv, input int epc);
    vec_t v;
    v.arm = a; v.capV = cv; v.pc = pc; v.rdy = r; v.expArmed = ea; v.expTrig = et; v.expDone = ed;
    v.expFill = ef; v.expTp = etp; v.expRv = erv; v.expPc = epc;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit a, input bit cv, input logic [15:0] pc, input logic [1:0] kind,
                               input bit frc, input bit rdy, input logic [15:0] ins,
                               input logic [15:0] tag, input logic [15:0] dat);
    arm = a; cap_valid = cv; cap_pc = pc; cap_kind = kind; force_trig = frc; rd_ready = rdy;
    cap_instr = ins; cap_tag = tag; cap_data = dat;
    tick();
  endtask

  task automatic applyFixed(input bit a, input bit cv, input int pc, input int kind, input bit frc,
                            input bit rdy);
    logic [EW-1:0] e;
    e = fixedEntry(pc, kind);
    applyStimulus(a, cv, 16'(pc), 2'(kind), frc, rdy, e[49:34], e[31:16], e[15:0]);
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drains expQ with the given ready pattern, checking order, stability and the final drop.
  task automatic drainQueue(input string tag, input bit randomReady);
    bit pat[6] = '{1, 0, 0, 1, 0, 1};
    int k = 0;
    bit r;
    while (expQ.size() > 0 && k < 200) begin
      checkOutput({tag, "_rd_valid"}, 128'(rd_valid), 128'(1));
      checkOutput({tag, "_rd_data"}, 128'(rd_data), 128'(expQ[0]));
      r = randomReady ? bit'($urandom_range(0, 1)) : pat[k % 6];
      applyStimulus(1'b0, randomReady ? bit'($urandom_range(0, 1)) : 1'b0, 16'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)), 1'b0, r, 16'($urandom), 16'($urandom), 16'($urandom));
      if (r) void'(expQ.pop_front());
      k++;
    end
    checkOutput({tag, "_drain_budget"}, 128'(expQ.size()), 128'(0));
    checkOutput({tag, "_rd_valid_end"}, 128'(rd_valid), 128'(0));
    checkOutput({tag, "_done_end"}, 128'(done), 128'(0));
  endtask

  task automatic runRandomTrial();
    bit mTrig = 0, mForce = 0, mDone = 0, hit, cv, frc;
    int mTrigIdx = 0, cyc = 0, f;
    logic [15:0] pc, ins, tg, dt;
    logic [1:0] kind;
    mList.delete();
    trig_en = bit'($urandom_range(0, 1));
    trig_pc = 16'($urandom_range(0, 15));
    applyStimulus(1'b1, 1'b0, 16'd0, 2'd0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
    while (!mDone && cyc < 300) begin
      cv = ($urandom_range(0, 3) != 0);
      pc = 16'($urandom_range(0, 15)); kind = 2'($urandom_range(0, 3));
      ins = 16'($urandom); tg = 16'($urandom); dt = 16'($urandom);
      frc = (cyc >= 40) || ($urandom_range(0, 15) == 0);
      applyStimulus(1'b0, cv, pc, kind, frc, 1'b0, ins, tg, dt);
      if (cv) begin
        hit = !mTrig && ((trig_en && pc == trig_pc) || mForce);
        if (!FILT || kind != 2'd0 || hit) mList.push_back({pc, ins, kind, tg, dt});
        if (hit) begin mTrig = 1; mForce = 0; mTrigIdx = mList.size() - 1; end
      end
      if (!mTrig && frc) mForce = 1;
      mDone = mTrig && (mList.size() - mTrigIdx - 1 == POST_TRIG);
      f = (mList.size() < DEPTH) ? mList.size() : DEPTH;
      checkOutput("rand_done", 128'(done), 128'(mDone));
      checkOutput("rand_triggered", 128'(triggered), 128'(mTrig));
      checkOutput("rand_armed", 128'(armed), 128'(!mDone));
      checkOutput("rand_fill", 128'(fill), 128'(f));
      cyc++;
    end
    checkOutput("rand_capture_budget", 128'(mDone), 128'(1));
    f = (mList.size() < DEPTH) ? mList.size() : DEPTH;
    checkOutput("rand_trig_pos", 128'(trig_pos), 128'(f - 1 - POST_TRIG));
    expQ.delete();
    for (int i = mList.size() - f; i < mList.size(); i++) expQ.push_back(mList[i]);
    drainQueue("rand", 1'b1);
  endtask

  initial begin
    rst = 1'b0; arm = 1'b1; cap_valid = 1'b1; cap_pc = 16'd2; cap_kind = 2'd1; force_trig = 1'b1;
    rd_ready = 1'b1; cap_instr = '0; cap_tag = '0; cap_data = '0; trig_en = 1'b1; trig_pc = 16'd2;

    // Reset held with capture and arm asserted: everything stays quiet.
    repeat (3) tick();
    checkOutput("rst_armed", 128'(armed), 128'(0));
    checkOutput("rst_triggered", 128'(triggered), 128'(0));
    checkOutput("rst_done", 128'(done), 128'(0));
    checkOutput("rst_fill", 128'(fill), 128'(0));
    checkOutput("rst_trig_pos", 128'(trig_pos), 128'(0));
    checkOutput("rst_rd_valid", 128'(rd_valid), 128'(0));
    checkOutput("rst_rd_data", 128'(rd_data), 128'(0));
    rst = 1'b1;
    applyFixed(1'b0, 1'b1, 5, 1, 1'b0, 1'b0);
    checkOutput("idle_armed", 128'(armed), 128'(0));
    checkOutput("idle_fill", 128'(fill), 128'(0));
    checkOutput("idle_rd_valid", 128'(rd_valid), 128'(0));

    // Basic trigger at pc 2 followed by full readout.
    vecs[0]  = mkVec(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, -1);
    vecs[1]  = mkVec(0, 1, 0, 0, 1, 0, 0, 1, 0, 0, -1);
    vecs[2]  = mkVec(0, 1, 1, 0, 1, 0, 0, 2, 0, 0, -1);
    vecs[3]  = mkVec(0, 1, 2, 0, 1, 1, 0, 3, -1, 0, -1);
    vecs[4]  = mkVec(0, 1, 3, 0, 1, 1, 0, 4, -1, 0, -1);
    vecs[5]  = mkVec(0, 1, 4, 0, 0, 1, 1, 5, 2, 1, 0);
    vecs[6]  = mkVec(0, 0, 0, 1, 0, 1, 1, 5, 2, 1, 1);
    vecs[7]  = mkVec(0, 0, 0, 1, 0, 1, 1, 5, 2, 1, 2);
    vecs[8]  = mkVec(0, 0, 0, 1, 0, 1, 1, 5, 2, 1, 3);
    vecs[9]  = mkVec(0, 0, 0, 1, 0, 1, 1, 5, 2, 1, 4);
    vecs[10] = mkVec(0, 0, 0, 1, 0, 0, 0, -1, 0, 0, -1);
    trig_en = 1'b1; trig_pc = 16'd2;
    for (int i = 0; i < 11; i++) begin
      applyFixed(vecs[i].arm, vecs[i].capV, vecs[i].pc, 1, 1'b0, vecs[i].rdy);
      checkOutput($sformatf("vec%0d_armed", i), 128'(armed), 128'(vecs[i].expArmed));
      checkOutput($sformatf("vec%0d_triggered", i), 128'(triggered), 128'(vecs[i].expTrig));
      checkOutput($sformatf("vec%0d_done", i), 128'(done), 128'(vecs[i].expDone));
      checkOutput($sformatf("vec%0d_rd_valid", i), 128'(rd_valid), 128'(vecs[i].expRv));
      if (vecs[i].expFill >= 0) checkOutput($sformatf("vec%0d_fill", i), 128'(fill), 128'(vecs[i].expFill));
      if (vecs[i].expTp >= 0) checkOutput($sformatf("vec%0d_trig_pos", i), 128'(trig_pos), 128'(vecs[i].expTp));
      if (vecs[i].expPc >= 0) checkOutput($sformatf("vec%0d_rd_data", i), 128'(rd_data), 128'(fixedEntry(vecs[i].expPc, 1)));
    end

    // Wrap past DEPTH, then drain with a stalling consumer.
    trig_pc = 16'd9;
    applyFixed(1'b1, 1'b0, 0, 1, 1'b0, 1'b0);
    for (int p = 0; p < 12; p++) applyFixed(1'b0, 1'b1, p, 1, 1'b0, 1'b0);
    checkOutput("wrap_done", 128'(done), 128'(1));
    checkOutput("wrap_fill", 128'(fill), 128'(8));
    checkOutput("wrap_trig_pos", 128'(trig_pos), 128'(5));
    expQ.delete();
    for (int p = 4; p < 12; p++) expQ.push_back(fixedEntry(p, 1));
    drainQueue("wrap", 1'b0);

    // Re-arm during POST together with a capture: the entry is dropped.
    trig_pc = 16'd1;
    applyFixed(1'b1, 1'b0, 0, 1, 1'b0, 1'b0);
    applyFixed(1'b0, 1'b1, 0, 1, 1'b0, 1'b0);
    applyFixed(1'b0, 1'b1, 1, 1, 1'b0, 1'b0);
    checkOutput("abort_post_state", 128'(triggered), 128'(1));
    applyFixed(1'b1, 1'b1, 1, 1, 1'b0, 1'b0);
    checkOutput("abort_armed", 128'(armed), 128'(1));
    checkOutput("abort_triggered", 128'(triggered), 128'(0));
    checkOutput("abort_fill", 128'(fill), 128'(0));
    applyFixed(1'b0, 1'b0, 0, 1, 1'b0, 1'b0);
    checkOutput("abort_fill_hold", 128'(fill), 128'(0));

    // Asynchronous reset in the middle of readout.
    trig_pc = 16'd2;
    applyFixed(1'b1, 1'b0, 0, 1, 1'b0, 1'b0);
    for (int p = 0; p < 5; p++) applyFixed(1'b0, 1'b1, p, 1, 1'b0, 1'b0);
    applyFixed(1'b0, 1'b0, 0, 1, 1'b0, 1'b1);
    checkOutput("midrd_rd_data", 128'(rd_data), 128'(fixedEntry(1, 1)));
    rd_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("midrd_rst_rd_valid", 128'(rd_valid), 128'(0));
    checkOutput("midrd_rst_done", 128'(done), 128'(0));
    checkOutput("midrd_rst_fill", 128'(fill), 128'(0));
    tick();
    rst = 1'b1;
    tick();
    checkOutput("midrd_idle_armed", 128'(armed), 128'(0));
    checkOutput("midrd_idle_rd_valid", 128'(rd_valid), 128'(0));

`ifdef TRACE_CHANGE_FILTER_EN
    begin
      int kinds[7] = '{0, 1, 0, 2, 0, 1, 2};
      trig_en = 1'b0;
      applyFixed(1'b1, 1'b0, 0, 1, 1'b0, 1'b0);
      for (int i = 1; i <= 7; i++) begin
        if (i == 3) applyFixed(1'b0, 1'b0, 0, 1, 1'b1, 1'b0);
        applyFixed(1'b0, 1'b1, i, kinds[i-1], 1'b0, 1'b0);
      end
      checkOutput("filt_done", 128'(done), 128'(1));
      checkOutput("filt_fill", 128'(fill), 128'(4));
      checkOutput("filt_trig_pos", 128'(trig_pos), 128'(1));
      expQ.delete();
      expQ.push_back(fixedEntry(2, 1)); expQ.push_back(fixedEntry(3, 0));
      expQ.push_back(fixedEntry(4, 2)); expQ.push_back(fixedEntry(6, 1));
      drainQueue("filt", 1'b0);
    end
`endif

    for (int t = 0; t < 25; t++) runRandomTrial();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
